// File: rtl/swc_alloc_req_arbiter.sv
// ============================================================================
// Module   : swc_alloc_req_arbiter
// Brief    : Round-robin request front end for the switch-core page allocator.
//            Optional statistics counters: define SWC_ALLOC_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swc_alloc_req_arbiter #(
    parameter int g_num_ports       = 7,
    parameter int g_page_addr_width = 10,
    parameter int g_usecount_width  = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [g_num_ports-1:0]                      rq_alloc_i,
    input  logic [g_num_ports-1:0]                      rq_free_i,
    input  logic [g_num_ports-1:0]                      rq_force_free_i,
    input  logic [g_num_ports-1:0]                      rq_set_usecnt_i,
    input  logic [g_num_ports*g_page_addr_width-1:0]    rq_pgaddr_i,
    input  logic [g_num_ports*g_usecount_width-1:0]     rq_usecnt_i,
    output logic [g_num_ports-1:0]                      rq_done_o,
    output logic [g_page_addr_width-1:0]                rq_pgaddr_o,
    output logic                                        rq_last_usecnt_o,
    output logic                                        rq_nomem_o,
    output logic                                        alloc_o,
    output logic                                        free_o,
    output logic                                        force_free_o,
    output logic                                        set_usecnt_o,
    output logic [g_page_addr_width-1:0]                pgaddr_o,
    output logic [g_usecount_width-1:0]                 usecnt_o,
    input  logic                                        done_i,
    input  logic [g_page_addr_width-1:0]                pgaddr_i,
    input  logic                                        free_last_usecnt_i,
    input  logic                                        nomem_i
`ifdef SWC_ALLOC_ARB_STATS_EN
    ,
    output logic [31:0]                                 stat_alloc_o,
    output logic [31:0]                                 stat_free_o,
    output logic [31:0]                                 stat_force_free_o,
    output logic [31:0]                                 stat_set_usecnt_o,
    output logic [31:0]                                 stat_nomem_stall_o
`endif
);

    localparam int c_IDX_W = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
    localparam logic [g_num_ports-1:0] c_ONE = {{(g_num_ports-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } t_state;

    t_state                         r_state;
    logic [c_IDX_W-1:0]             r_ptr;
    logic [c_IDX_W-1:0]             r_grant;
    logic                           r_alloc, r_free, r_force_free, r_set_usecnt;
    logic [g_page_addr_width-1:0]   r_pgaddr;
    logic [g_usecount_width-1:0]    r_usecnt;
    logic [g_num_ports-1:0]         r_done;
    logic [g_page_addr_width-1:0]   r_rq_pgaddr;
    logic                           r_last_usecnt;
    logic                           r_nomem;

    logic [g_num_ports-1:0]         w_non_alloc;
    logic [g_num_ports-1:0]         w_elig;
    logic [c_IDX_W-1:0]             w_sel;
    logic [c_IDX_W-1:0]             w_next_ptr;
    logic                           w_found;
    int                             w_idx;
    logic                           w_sel_ff, w_sel_fr, w_sel_su;
    logic [g_page_addr_width-1:0]   w_sel_pg;
    logic [g_usecount_width-1:0]    w_sel_uc;

    // Alloc-only requests are masked while the allocator is out of pages.
    assign w_non_alloc = rq_free_i | rq_force_free_i | rq_set_usecnt_i;
    assign w_elig      = w_non_alloc | (rq_alloc_i & {g_num_ports{~nomem_i}});

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int k = 0; k < g_num_ports; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= g_num_ports) begin
                w_idx = w_idx - g_num_ports;
            end
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(w_idx);
            end
        end
    end

    assign w_next_ptr = (int'(w_sel) == g_num_ports - 1) ? '0 : w_sel + 1'b1;
    assign w_sel_ff   = rq_force_free_i[w_sel];
    assign w_sel_fr   = rq_free_i[w_sel];
    assign w_sel_su   = rq_set_usecnt_i[w_sel];
    assign w_sel_pg   = rq_pgaddr_i[int'(w_sel)*g_page_addr_width +: g_page_addr_width];
    assign w_sel_uc   = rq_usecnt_i[int'(w_sel)*g_usecount_width +: g_usecount_width];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_alloc       <= 1'b0;
            r_free        <= 1'b0;
            r_force_free  <= 1'b0;
            r_set_usecnt  <= 1'b0;
            r_pgaddr      <= '0;
            r_usecnt      <= '0;
            r_done        <= '0;
            r_rq_pgaddr   <= '0;
            r_last_usecnt <= 1'b0;
            r_nomem       <= 1'b0;
        end else begin
            r_nomem <= nomem_i;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_sel;
                        r_ptr        <= w_next_ptr;
                        r_pgaddr     <= w_sel_pg;
                        r_usecnt     <= w_sel_uc;
                        r_force_free <= w_sel_ff;
                        r_free       <= ~w_sel_ff & w_sel_fr;
                        r_set_usecnt <= ~w_sel_ff & ~w_sel_fr & w_sel_su;
                        r_alloc      <= ~w_sel_ff & ~w_sel_fr & ~w_sel_su;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (done_i) begin
                        r_alloc       <= 1'b0;
                        r_free        <= 1'b0;
                        r_force_free  <= 1'b0;
                        r_set_usecnt  <= 1'b0;
                        r_rq_pgaddr   <= pgaddr_i;
                        r_last_usecnt <= free_last_usecnt_i;
                        r_done        <= c_ONE << r_grant;
                        r_state       <= S_RESP;
                    end
                end
                // Dead cycle lets the requester drop its level request.
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alloc_o          = r_alloc;
    assign free_o           = r_free;
    assign force_free_o     = r_force_free;
    assign set_usecnt_o     = r_set_usecnt;
    assign pgaddr_o         = r_pgaddr;
    assign usecnt_o         = r_usecnt;
    assign rq_done_o        = r_done;
    assign rq_pgaddr_o      = r_rq_pgaddr;
    assign rq_last_usecnt_o = r_last_usecnt;
    assign rq_nomem_o       = r_nomem;

`ifdef SWC_ALLOC_ARB_STATS_EN
    logic [31:0] r_stat_alloc, r_stat_free, r_stat_force_free, r_stat_set_usecnt, r_stat_stall;
    logic        w_complete;
    logic        w_stall;

    assign w_complete = (r_state == S_BUSY) && done_i;
    assign w_stall    = (r_state == S_IDLE) && nomem_i && |(rq_alloc_i & ~w_non_alloc);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stat_alloc      <= '0;
            r_stat_free       <= '0;
            r_stat_force_free <= '0;
            r_stat_set_usecnt <= '0;
            r_stat_stall      <= '0;
        end else begin
            if (w_complete && r_alloc)      r_stat_alloc      <= r_stat_alloc + 32'd1;
            if (w_complete && r_free)       r_stat_free       <= r_stat_free + 32'd1;
            if (w_complete && r_force_free) r_stat_force_free <= r_stat_force_free + 32'd1;
            if (w_complete && r_set_usecnt) r_stat_set_usecnt <= r_stat_set_usecnt + 32'd1;
            if (w_stall)                    r_stat_stall      <= r_stat_stall + 32'd1;
        end
    end

    assign stat_alloc_o       = r_stat_alloc;
    assign stat_free_o        = r_stat_free;
    assign stat_force_free_o  = r_stat_force_free;
    assign stat_set_usecnt_o  = r_stat_set_usecnt;
    assign stat_nomem_stall_o = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_swc_alloc_req_arbiter.sv
// ============================================================================
// Module   : tb_swc_alloc_req_arbiter
// Brief    : Directed bench for swc_alloc_req_arbiter with a behavioural
//            allocator model and a short random operation mix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swc_alloc_req_arbiter;

    localparam int NP = 7;
    localparam int AW = 10;
    localparam int UW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     rq_alloc = '0, rq_free = '0, rq_ff = '0, rq_su = '0;
    logic [NP*AW-1:0]  rq_pgaddr = '0;
    logic [NP*UW-1:0]  rq_usecnt = '0;
    logic [NP-1:0]     rq_done;
    logic [AW-1:0]     rq_pgaddr_o;
    logic              rq_last_usecnt, rq_nomem;
    logic              alloc_o, free_o, force_free_o, set_usecnt_o;
    logic [AW-1:0]     pgaddr_o;
    logic [UW-1:0]     usecnt_o;
    logic              done_i = 1'b0;
    logic [AW-1:0]     pgaddr_i = '0;
    logic              free_last_usecnt_i = 1'b0;
    logic              nomem_i = 1'b0;
`ifdef SWC_ALLOC_ARB_STATS_EN
    logic [31:0]       st_al, st_fr, st_ff, st_su, st_stall;
`endif

    always #5 clk = ~clk;

    swc_alloc_req_arbiter dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .rq_alloc_i         (rq_alloc),
        .rq_free_i          (rq_free),
        .rq_force_free_i    (rq_ff),
        .rq_set_usecnt_i    (rq_su),
        .rq_pgaddr_i        (rq_pgaddr),
        .rq_usecnt_i        (rq_usecnt),
        .rq_done_o          (rq_done),
        .rq_pgaddr_o        (rq_pgaddr_o),
        .rq_last_usecnt_o   (rq_last_usecnt),
        .rq_nomem_o         (rq_nomem),
        .alloc_o            (alloc_o),
        .free_o             (free_o),
        .force_free_o       (force_free_o),
        .set_usecnt_o       (set_usecnt_o),
        .pgaddr_o           (pgaddr_o),
        .usecnt_o           (usecnt_o),
        .done_i             (done_i),
        .pgaddr_i           (pgaddr_i),
        .free_last_usecnt_i (free_last_usecnt_i),
        .nomem_i            (nomem_i)
`ifdef SWC_ALLOC_ARB_STATS_EN
        ,
        .stat_alloc_o       (st_al),
        .stat_free_o        (st_fr),
        .stat_force_free_o  (st_ff),
        .stat_set_usecnt_o  (st_su),
        .stat_nomem_stall_o (st_stall)
`endif
    );

    // Strobe vector {force_free, free, set_usecnt, alloc}
    localparam logic [3:0] T_FF = 4'b1000, T_FR = 4'b0100, T_SU = 4'b0010, T_AL = 4'b0001;
    logic [3:0] strb;
    assign strb = {force_free_o, free_o, set_usecnt_o, alloc_o};

    int n_checks = 0;
    int n_bad    = 0;
    int onehot_err = 0;
    int c_al = 0, c_fr = 0, c_ff = 0, c_su = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural allocator: done_i after 'lat' strobe cycles.
    int            lat = 1;
    int            mcnt = 0;
    logic [AW-1:0] model_page = '0;
    logic          model_last = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_i = 1'b0;
                mcnt   = 0;
            end else if (done_i) begin
                done_i = 1'b0;
                mcnt   = 0;
            end else if (strb != 4'b0000) begin
                mcnt++;
                if (mcnt >= lat) begin
                    done_i             = 1'b1;
                    pgaddr_i           = model_page;
                    free_last_usecnt_i = model_last;
                end
            end
        end
    end

    always @(negedge clk) begin
        if ($countones(strb) > 1) onehot_err++;
    end

    task automatic set_rq(input int p, input logic [3:0] t, input logic [AW-1:0] pg,
                          input logic [UW-1:0] uc);
        if (t[3]) rq_ff[p]    = 1'b1;
        if (t[2]) rq_free[p]  = 1'b1;
        if (t[1]) rq_su[p]    = 1'b1;
        if (t[0]) rq_alloc[p] = 1'b1;
        rq_pgaddr[p*AW +: AW] = pg;
        rq_usecnt[p*UW +: UW] = uc;
    endtask

    task automatic clr_rq(input int p, input logic [3:0] t);
        if (t[3]) rq_ff[p]    = 1'b0;
        if (t[2]) rq_free[p]  = 1'b0;
        if (t[1]) rq_su[p]    = 1'b0;
        if (t[0]) rq_alloc[p] = 1'b0;
    endtask

    task automatic tally(input logic [3:0] t);
        case (t)
            T_FF:    c_ff++;
            T_FR:    c_fr++;
            T_SU:    c_su++;
            T_AL:    c_al++;
            default: ;
        endcase
    endtask

    // Returns the port completed, the strobe seen and its page address.
    task automatic wait_done(output int port, output logic [3:0] t, output logic [AW-1:0] pg);
        port = -1;
        t    = '0;
        pg   = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (strb != 4'b0000) begin
                t  = strb;
                pg = pgaddr_o;
            end
            if (rq_done != '0) begin
                for (int q = 0; q < NP; q++) if (rq_done[q]) port = q;
                break;
            end
        end
        if (port < 0) check("wait_done_timeout", 32'd0, 32'd1);
        else tally(t);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int            gp;
        logic [3:0]    gt;
        logic [AW-1:0] gpg;
        int            exp_ports[4];
        bit            pend[NP];
        logic [3:0]    ptyp[NP];
        int            issued, completed, spurious, cyc;
        bit            any_pend;
        exp_ports = '{0, 3, 6, 0};

        // Reset state
        @(negedge clk);
        check("rst_strobes", 32'(strb), 32'h0);
        check("rst_done", 32'(rq_done), 32'h0);
        check("rst_pgaddr_o", 32'(pgaddr_o), 32'h0);
        check("rst_rq_pgaddr", 32'(rq_pgaddr_o), 32'h0);
        check("rst_nomem", 32'(rq_nomem), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Port 2 alloc, usecnt 3, 2-cycle allocator returning page 17
        lat = 2;
        model_page = 10'd17;
        set_rq(2, T_AL, '0, 4'd3);
        @(negedge clk);
        check("t1_alloc_strobe", 32'(strb), 32'(T_AL));
        check("t1_usecnt", 32'(usecnt_o), 32'd3);
        @(negedge clk);
        check("t1_alloc_held", 32'(strb), 32'(T_AL));
        @(negedge clk);
        check("t1_done", 32'(rq_done), 32'b0000100);
        check("t1_rq_pgaddr", 32'(rq_pgaddr_o), 32'd17);
        check("t1_strobe_off", 32'(strb), 32'h0);
        clr_rq(2, T_AL);
        @(negedge clk);
        check("t1_done_pulse", 32'(rq_done), 32'h0);
        check("t1_pgaddr_hold", 32'(rq_pgaddr_o), 32'd17);

        // Reset while BUSY clears strobes asynchronously
        lat = 20;
        set_rq(2, T_AL, '0, 4'd1);
        @(negedge clk);
        check("rb_busy", 32'(strb), 32'(T_AL));
        #2 rst_n = 1'b0;
        #1;
        check("rb_strobes_async", 32'(strb), 32'h0);
        check("rb_done_async", 32'(rq_done), 32'h0);
        clr_rq(2, T_AL);
        c_al = 0; c_fr = 0; c_ff = 0; c_su = 0;
        lat = 1;
        set_rq(0, T_AL, '0, 4'd1);
        set_rq(3, T_AL, '0, 4'd1);
        set_rq(6, T_AL, '0, 4'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin among continuous requesters 0, 3, 6
        for (int i = 0; i < 4; i++) begin
            wait_done(gp, gt, gpg);
            check($sformatf("rr_port%0d", i), 32'(gp), 32'(exp_ports[i]));
        end
        clr_rq(0, T_AL);
        clr_rq(3, T_AL);
        clr_rq(6, T_AL);
        @(negedge clk);
        @(negedge clk);

        // force_free beats free on the same port
        model_last = 1'b1;
        set_rq(1, T_FF | T_FR, 10'd5, 4'd0);
        wait_done(gp, gt, gpg);
        check("pri_ff_port", 32'(gp), 32'd1);
        check("pri_ff_type", 32'(gt), 32'(T_FF));
        check("pri_ff_pg", 32'(gpg), 32'd5);
        check("pri_ff_last", 32'(rq_last_usecnt), 32'd1);
        clr_rq(1, T_FF);
        model_last = 1'b0;
        wait_done(gp, gt, gpg);
        check("pri_fr_port", 32'(gp), 32'd1);
        check("pri_fr_type", 32'(gt), 32'(T_FR));
        check("pri_fr_last", 32'(rq_last_usecnt), 32'd0);
        clr_rq(1, T_FR);
        @(negedge clk);

        // nomem masks alloc-only port 4, free on port 5 proceeds
        nomem_i = 1'b1;
        set_rq(4, T_AL, '0, 4'd2);
        set_rq(5, T_FR, 10'd9, 4'd0);
        wait_done(gp, gt, gpg);
        check("nm_free_port", 32'(gp), 32'd5);
        check("nm_free_type", 32'(gt), 32'(T_FR));
        check("nm_free_pg", 32'(gpg), 32'd9);
        clr_rq(5, T_FR);
        gt = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gt = gt | strb;
        end
        check("nm_no_alloc", 32'(gt), 32'h0);
        check("nm_rq_nomem", 32'(rq_nomem), 32'd1);
`ifdef SWC_ALLOC_ARB_STATS_EN
        check("nm_stall_cnt", 32'(st_stall >= 32'd6), 32'd1);
`endif
        nomem_i = 1'b0;
        wait_done(gp, gt, gpg);
        check("nm_alloc_port", 32'(gp), 32'd4);
        check("nm_alloc_type", 32'(gt), 32'(T_AL));
        clr_rq(4, T_AL);
        @(negedge clk);

        // Random mix: one request type per port at a time
        issued = 0; completed = 0; spurious = 0; cyc = 0;
        for (int p = 0; p < NP; p++) begin
            pend[p] = 1'b0;
            ptyp[p] = '0;
        end
        any_pend = 1'b0;
        while ((issued < 300 || any_pend) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (rq_done[p]) begin
                    if (!pend[p]) spurious++;
                    else begin
                        clr_rq(p, ptyp[p]);
                        tally(ptyp[p]);
                        pend[p] = 1'b0;
                        completed++;
                    end
                end
            end
            nomem_i    = ($urandom_range(0, 7) == 0);
            lat        = int'($urandom_range(1, 3));
            model_page = AW'($urandom);
            any_pend   = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && issued < 300 && $urandom_range(0, 3) == 0) begin
                    ptyp[p] = 4'(4'b0001 << $urandom_range(0, 3));
                    set_rq(p, ptyp[p], AW'($urandom), UW'($urandom));
                    pend[p] = 1'b1;
                    issued++;
                end
                if (pend[p]) any_pend = 1'b1;
            end
        end
        nomem_i = 1'b0;
        check("mix_all_done", 32'(completed), 32'(issued));
        check("mix_issued", 32'(issued), 32'd300);
        check("mix_spurious", 32'(spurious), 32'd0);
        check("onehot_strobes", 32'(onehot_err), 32'd0);
`ifdef SWC_ALLOC_ARB_STATS_EN
        check("stat_alloc", st_al, 32'(c_al));
        check("stat_free", st_fr, 32'(c_fr));
        check("stat_force_free", st_ff, 32'(c_ff));
        check("stat_set_usecnt", st_su, 32'(c_su));
        check("stat_sum", st_al + st_fr + st_ff + st_su, 32'(c_al + c_fr + c_ff + c_su));
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
